// File: rtl/cpu_fetch_pkg.sv
// rtl/cpu_fetch_pkg.sv - shared types and constants for the instruction fetch unit
// Purpose: fetch FSM state encoding, FIFO entry layout and word size.
// Ports: none (package).
package cpu_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  localparam logic [31:0] WORD_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO of {instr, pc} entries with synchronous clear
// Purpose: DEPTH-entry circular buffer; head entry is read straight from the storage
//          registers, so a word pushed on an edge is visible at the head right after it.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push_i/entry_i  write entry_i at the tail (caller guarantees a free slot)
//   pop_i           drop the head entry (caller guarantees non-empty)
//   clear_i         empty the FIFO; overrides push and pop
//   count_o         occupancy, 0..DEPTH
//   head_o          current head entry
module fetch_fifo
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  fetch_entry_t               entry_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output fetch_entry_t               head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [CW-1:0]  count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= entry_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch front end with prefetch FIFO and redirect
// Purpose: issues one-at-a-time word reads to instruction memory, buffers the returned
//          words with their PC and hands them to decode; a redirect flushes and restarts.
// Optional feature: define FETCH_STATS_EN to add the stat_fetched/stat_flushed counters.
// Ports:
//   clk, reset                         clock, asynchronous active-low reset
//   imem_req_valid/ready/addr          read request channel
//   imem_rsp_valid/data                read response (in order, never in accept cycle)
//   redirect, redirect_pc              taken branch: flush and refetch at target
//   instr_valid/ready, Instr, instr_pc decode-side output channel
//   stat_fetched, stat_flushed         (FETCH_STATS_EN only) word counters
module instr_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
`ifdef FETCH_STATS_EN
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_flushed,
`endif
  output logic [31:0] Instr,
  output logic [31:0] instr_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic          push, pop;

  // Redirect wins over everything: no push, no pop, FIFO cleared.
  assign push     = (state_q == WAIT) && imem_rsp_valid && !redirect;
  assign pop      = instr_valid && instr_ready && !redirect;
  // Occupancy after this edge; used so a slot freed by a pop is requested straight away.
  assign count_nx = redirect ? '0 : (count + CW'(push) - CW'(pop));

  assign push_entry.instr = imem_rsp_data;
  assign push_entry.pc    = fetch_pc_q;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .clear_i (redirect),
    .count_o (count),
    .head_o  (head)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // fetch_pc_q is the address of the request being issued or awaited; it only advances
  // when that request's word is pushed.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (push) begin
      fetch_pc_d = fetch_pc_q + WORD_BYTES;
    end
    if (redirect) begin
      fetch_pc_d = redirect_pc & ~32'h3;
      case (state_q)
        // Accepted this very cycle: memory still owes a response for the old address.
        REQ:        state_d = imem_req_ready ? DROP : REQ;
        // A response arriving now is discarded and settles the debt.
        WAIT, DROP: state_d = imem_rsp_valid ? REQ : DROP;
        default:    state_d = REQ;
      endcase
    end else begin
      case (state_q)
        IDLE:    if (count_nx < DEPTH_C) state_d = REQ;
        REQ:     if (imem_req_ready) state_d = WAIT;
        WAIT:    if (imem_rsp_valid) state_d = (count_nx < DEPTH_C) ? REQ : IDLE;
        DROP:    if (imem_rsp_valid) state_d = REQ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = fetch_pc_q;
  assign instr_valid    = (count != '0);
  assign Instr          = head.instr;
  assign instr_pc       = head.pc;

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_q;
  logic [31:0] stat_flushed_q;
  logic        rsp_drop;

  assign rsp_drop = imem_rsp_valid && ((state_q == DROP) || ((state_q == WAIT) && redirect));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_fetched_q <= '0;
      stat_flushed_q <= '0;
    end else begin
      stat_fetched_q <= stat_fetched_q + 32'(push);
      stat_flushed_q <= stat_flushed_q + (redirect ? 32'(count) : 32'd0) + 32'(rsp_drop);
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_flushed = stat_flushed_q;
`endif

endmodule
